// File: rtl/fifo_rr_sched.sv
// Round-robin scheduler draining NREQ FIFOs into one registered valid/ready output stage.
// Optional build macro FIFO_SCHED_STRICT_EN gives queue 0 strict, non-disturbing priority.
module fifo_rr_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 256,
  parameter int unsigned QUANTUM = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          q_empty,
  input  logic [NREQ*WIDTH-1:0]    q_data,
  output logic [NREQ-1:0]          q_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(NREQ)-1:0]  out_src
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(QUANTUM + 1);
  localparam logic [CW-1:0] QMAX = CW'(QUANTUM);

`ifdef FIFO_SCHED_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, nxt_state;
  logic [IW-1:0]   cur, nxt_cur;
  logic [IW-1:0]   rr_ptr, nxt_rr;
  logic [CW-1:0]   cnt, nxt_cnt;

  logic            slot_free;
  logic            eligible_cur;
  logic [IW-1:0]   base;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   sel;
  logic            found;
  logic            do_pop;
  logic [IW-1:0]   pop_idx;
  logic [WIDTH-1:0] pop_data;

  // Modular index increment; valid for non-power-of-2 NREQ.
  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] a, input int unsigned off);
    return IW'((32'(a) + off) % NREQ);
  endfunction

  // Round-robin search for the first non-empty queue starting at base.
  always_comb begin
    slot_free    = !out_valid || out_ready;
    eligible_cur = (state == BURST) && !q_empty[cur] && (cnt < QMAX);
    base         = (state == BURST) ? idx_add(cur, 1) : rr_ptr;
    found        = 1'b0;
    sel          = '0;
    cand         = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = idx_add(base, off);
      if (!found && !q_empty[cand] && !(STRICT && (cand == '0))) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Pop decision and next grant state.
  always_comb begin
    do_pop    = 1'b0;
    pop_idx   = cur;
    nxt_state = state;
    nxt_cur   = cur;
    nxt_cnt   = cnt;
    nxt_rr    = rr_ptr;
    if (!rst && slot_free) begin
      if (STRICT && !q_empty[0]) begin
        // Priority pop leaves the suspended burst untouched.
        do_pop  = 1'b1;
        pop_idx = '0;
      end else if (eligible_cur) begin
        do_pop  = 1'b1;
        pop_idx = cur;
        nxt_cnt = cnt + CW'(1);
      end else if (found) begin
        do_pop    = 1'b1;
        pop_idx   = sel;
        nxt_cur   = sel;
        nxt_cnt   = CW'(1);
        nxt_state = BURST;
        nxt_rr    = idx_add(sel, 1);
      end else begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        if (state == BURST) nxt_rr = idx_add(cur, 1);
      end
    end
  end

  // Pop strobe and head-word select.
  always_comb begin
    q_rd     = '0;
    pop_data = '0;
    if (do_pop) q_rd[pop_idx] = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pop_idx == IW'(i)) pop_data = q_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      state  <= nxt_state;
      cur    <= nxt_cur;
      cnt    <= nxt_cnt;
      rr_ptr <= nxt_rr;
      if (do_pop) begin
        out_valid <= 1'b1;
        out_data  <= pop_data;
        out_src   <= pop_idx;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Scoreboard bench for fifo_rr_sched: queue-level reference model, directed scenarios, random traffic.
module tb_fifo_rr_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned WIDTH   = 256;
  localparam int unsigned QUANTUM = 2;
  localparam int unsigned IW      = 2;

`ifdef FIFO_SCHED_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       q_empty;
  logic [NREQ*WIDTH-1:0] q_data;
  logic [NREQ-1:0]       q_rd;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IW-1:0]         out_src;

  fifo_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .QUANTUM(QUANTUM)) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_data(q_data), .q_rd(q_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0]    src;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] fq[NREQ][$];
  int               src_log[$];
  int               cyc_log[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               pend     = -1;
  int               cyc      = 0;

  // Reference model state: the grant expressed as queue index plus words taken.
  bit m_valid = 1'b0;
  bit m_burst = 1'b0;
  int m_cur   = 0;
  int m_cnt   = 0;
  int m_rr    = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      q_empty[i] = (fq[i].size() == 0);
      q_data[i*WIDTH +: WIDTH] = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) fq[k].push_back(rnd_word());
    drive();
  endtask

  task automatic step(input bit rdy);
    @(posedge clk);
    #2;
    if (pend >= 0) void'(fq[pend].pop_front());
    pend      = -1;
    out_ready = rdy;
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while ((!all_empty() || m_valid) && n < 300) begin
      step(1'b1);
      n++;
    end
    step(1'b1);
    check("drain_bound", 1'(n < 300), 1'b1);
  endtask

  task automatic check_log(input string name, input int exp[]);
    check({name, "_len"}, WIDTH'(src_log.size()), WIDTH'(exp.size()));
    for (int i = 0; i < exp.size() && i < src_log.size(); i++)
      check(name, WIDTH'(src_log[i]), WIDTH'(exp[i]));
  endtask

  always @(posedge clk) cyc++;

  // Reference model: decides expected pop from queue occupancy each cycle.
  task automatic model_step();
    logic [NREQ-1:0] exp_rd;
    bit slot_free;
    int k, base, s, idx;
    exp_rd = '0;
    if (rst) begin
      check("q_rd_in_reset", q_rd, '0);
      m_valid = 0; m_burst = 0; m_cur = 0; m_cnt = 0; m_rr = 0;
      sb.delete();
      return;
    end
    check("out_valid", out_valid, m_valid);
    slot_free = !m_valid || out_ready;
    k = -1;
    if (slot_free) begin
      if (STRICT && fq[0].size() > 0) begin
        k = 0;
      end else if (m_burst && fq[m_cur].size() > 0 && m_cnt < QUANTUM) begin
        k = m_cur;
        m_cnt++;
      end else begin
        base = m_burst ? (m_cur + 1) % NREQ : m_rr;
        s = -1;
        for (int off = 0; off < NREQ; off++) begin
          idx = (base + off) % NREQ;
          if (s < 0 && fq[idx].size() > 0 && !(STRICT && idx == 0)) s = idx;
        end
        if (s >= 0) begin
          k = s; m_cur = s; m_cnt = 1; m_rr = (s + 1) % NREQ; m_burst = 1;
        end else begin
          if (m_burst) m_rr = (m_cur + 1) % NREQ;
          m_burst = 0;
          m_cnt = 0;
        end
      end
    end
    if (k >= 0) exp_rd[k] = 1'b1;
    check("q_rd", q_rd, exp_rd);
    if (k >= 0) begin
      sb.push_back({IW'(k), fq[k][0]});
      pend    = k;
      m_valid = 1'b1;
    end else if (slot_free) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      model_step();
    end
  end

  // Monitor: compares every accepted output word against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got word from src %0d, expected none (cycle %0d)", out_src, cyc);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_src", out_src, e.src);
        end
        src_log.push_back(int'(out_src));
        cyc_log.push_back(cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive();
    repeat (3) step(1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_src", out_src, '0);
    check("rst_q_rd", q_rd, '0);
    rst = 1'b0;
    step(1'b1);

    // All queues with 3 words.
    src_log.delete(); cyc_log.delete();
    for (int i = 0; i < NREQ; i++) load(i, 3);
    drain();
    if (!STRICT) check_log("seq_all3", '{0,0,1,1,2,2,3,3,0,1,2,3});
    check("all3_no_bubble", WIDTH'(cyc_log[cyc_log.size()-1] - cyc_log[0]), WIDTH'(11));

    // Single queue longer than the quantum.
    src_log.delete(); cyc_log.delete();
    load(2, 5);
    drain();
    check_log("seq_q2", '{2,2,2,2,2});
    check("q2_no_bubble", WIDTH'(cyc_log[4] - cyc_log[0]), WIDTH'(4));

    // Backpressure holds the output stage.
    src_log.delete(); cyc_log.delete();
    load(1, 2);
    step(1'b0);
    repeat (4) step(1'b0);
    check("stall_src", out_src, 1);
    check("stall_valid", out_valid, 1'b1);
    drain();
    check_log("seq_stall", '{1,1});

    // rr_ptr steered to 3, then queues 3 and 0.
    src_log.delete(); cyc_log.delete();
    load(2, 1);
    drain();
    src_log.delete();
    load(3, 1);
    load(0, 2);
    drain();
    if (!STRICT) check_log("seq_wrap", '{3,0,0});

    // Reset mid-burst with a held output word.
    load(1, 4);
    step(1'b1);
    step(1'b0);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, '0);
    check("mid_rst_q_rd", q_rd, '0);
    src_log.delete(); cyc_log.delete();
    load(3, 1);
    drain();
    if (src_log.size() > 0) check("post_rst_first", WIDTH'(src_log[0]), WIDTH'(1));
    else check("post_rst_first_len", WIDTH'(0), WIDTH'(1));

    // Random traffic with random backpressure and an occasional reset.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 9) < 4) begin
        int k = $urandom_range(0, NREQ - 1);
        if (fq[k].size() < 8) load(k, 1);
      end
      if (c == 1500) begin
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        drive();
      end
    end
    drain();
    check("sb_empty_end", WIDTH'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
